// File: rtl/reset_sequencer.sv
// Sequenced reset generator: asserts the masked reset lines together, holds them
// for PULSE_CYCLES+EXT cycles, then releases them one by one in ascending order.
module reset_sequencer #(
    parameter int N_OUT        = 4,
    parameter int PULSE_CYCLES = 16,
    parameter int GAP_CYCLES   = 4
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic [31:0]      ctrl_word,
    input  logic             ctrl_wr_stb,
    output logic [N_OUT-1:0] rst_out,
    output logic             busy,
    output logic             done,
    output logic [1:0]       status,
    output logic [1:0]       dbg_state
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    localparam int MAX_CNT = (PULSE_CYCLES + 255 > GAP_CYCLES) ? PULSE_CYCLES + 255 : GAP_CYCLES;
    localparam int CNT_W   = ($clog2(MAX_CNT + 1) < 9) ? 9 : $clog2(MAX_CNT + 1);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [7:0]       r_ext, w_ext_nxt;
    logic [N_OUT-1:0] r_rst, w_rst_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic [1:0]       r_status, w_status_nxt;

    // Handshake: ctrl_wr_stb qualifies ctrl_word for exactly one cycle. There is no
    // back-pressure, so a GO request seen while busy is dropped and flagged as overrun.
    logic             w_req;
    logic [N_OUT-1:0] w_mask;
    logic             w_accept;
    logic [N_OUT-1:0] w_lowest;
    logic [N_OUT-1:0] w_remaining;
    logic [CNT_W-1:0] w_hold_last;
    logic [CNT_W-1:0] w_gap_last;
    logic             w_release;

    assign w_req       = ctrl_wr_stb & ctrl_word[31];
    assign w_mask      = ctrl_word[N_OUT-1:0];
    assign w_accept    = w_req && (r_state == ST_IDLE) && (w_mask != '0);
    // Isolate the lowest asserted line; only masked lines are ever high.
    assign w_lowest    = r_rst & (~r_rst + N_OUT'(1));
    assign w_remaining = r_rst & ~w_lowest;
    assign w_hold_last = CNT_W'(PULSE_CYCLES - 1) + CNT_W'(r_ext);
    assign w_gap_last  = CNT_W'(GAP_CYCLES - 1);
    assign w_release   = ((r_state == ST_HOLD) && (r_cnt == w_hold_last)) ||
                         ((r_state == ST_RELEASE) && (r_cnt == w_gap_last));

    // Reset loads the same context as an accepted all-channel request.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state  <= ST_HOLD;
            r_cnt    <= '0;
            r_ext    <= '0;
            r_rst    <= '1;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
            r_status <= 2'b00;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_ext    <= w_ext_nxt;
            r_rst    <= w_rst_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_status <= w_status_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_nxt = ST_HOLD;
            end
            ST_HOLD, ST_RELEASE: begin
                if (w_release) w_state_nxt = (w_remaining == '0) ? ST_IDLE : ST_RELEASE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_cnt_nxt    = (r_state == ST_IDLE) ? r_cnt : r_cnt + CNT_W'(1);
        w_ext_nxt    = r_ext;
        w_rst_nxt    = r_rst;
        w_status_nxt = r_status;
        w_done_nxt   = 1'b0;
        w_busy_nxt   = (w_state_nxt != ST_IDLE);
        if (w_accept) begin
            w_cnt_nxt    = '0;
            w_ext_nxt    = ctrl_word[15:8];
            w_rst_nxt    = w_mask;
            w_status_nxt = 2'b00;
        end else if (w_req) begin
            if (r_busy)
                w_status_nxt[1] = 1'b1;
            else if (w_mask == '0)
                w_status_nxt[0] = 1'b1;
        end
        if (w_release) begin
            w_cnt_nxt  = '0;
            w_rst_nxt  = w_remaining;
            w_done_nxt = (w_remaining == '0);
        end
    end

    assign rst_out   = r_rst;
    assign busy      = r_busy;
    assign done      = r_done;
    assign status    = r_status;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed scenarios plus random traffic, all checked
// cycle by cycle against a timeline model of each accepted request.
module tb_reset_sequencer;
    localparam int N     = 4;
    localparam int PULSE = 16;
    localparam int GAP   = 4;

    logic         ACLK = 1'b0;
    logic         ARESET;
    logic [31:0]  ctrl_word;
    logic         ctrl_wr_stb;
    logic [N-1:0] rst_out;
    logic         busy;
    logic         done;
    logic [1:0]   status;
    logic [1:0]   dbg_state;
    wire  [N+3:0] obs = {rst_out, busy, done, status};

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: the latest accepted request as a timeline of release cycles.
    int           t_acc    = -1000;
    int           last_rel = -1000;
    int           rel_t[N];
    logic [N-1:0] m_mask   = '0;
    logic [1:0]   m_status = 2'b00;

    reset_sequencer #(.N_OUT(N), .PULSE_CYCLES(PULSE), .GAP_CYCLES(GAP)) dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .ctrl_word   (ctrl_word),
        .ctrl_wr_stb (ctrl_wr_stb),
        .rst_out     (rst_out),
        .busy        (busy),
        .done        (done),
        .status      (status),
        .dbg_state   (dbg_state)
    );

    always #5 ACLK = ~ACLK;

    task automatic model_accept(input int t, input logic [N-1:0] mask, input int ext);
        int k;
        k = 0;
        t_acc    = t;
        m_mask   = mask;
        m_status = 2'b00;
        for (int i = 0; i < N; i++) begin
            rel_t[i] = 0;
            if (mask[i]) begin
                rel_t[i] = t + PULSE + ext + 1 + k * GAP;
                last_rel = rel_t[i];
                k++;
            end
        end
    endtask

    function automatic logic m_busy(input int c);
        return (c > t_acc) && (c < last_rel);
    endfunction

    function automatic logic [N+3:0] exp_obs(input int c);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++)
            r[i] = m_mask[i] && (c > t_acc) && (c < rel_t[i]);
        return {r, m_busy(c), (c == last_rel), m_status};
    endfunction

    // Applies the effect of the clock edge that ends cycle cyc, using current inputs.
    task automatic model_step();
        if (ARESET) begin
            model_accept(cyc, '1, 0);
        end else if (ctrl_wr_stb && ctrl_word[31]) begin
            if (m_busy(cyc))
                m_status[1] = 1'b1;
            else if (ctrl_word[N-1:0] == '0)
                m_status[0] = 1'b1;
            else
                model_accept(cyc, ctrl_word[N-1:0], int'(ctrl_word[15:8]));
        end
        cyc++;
    endtask

    task automatic drive_stb(input logic [31:0] w);
        ctrl_word   = w;
        ctrl_wr_stb = 1'b1;
    endtask

    task automatic drive_idle();
        ctrl_wr_stb = 1'b0;
    endtask

    task automatic test_reset();
        int c0;
        c0 = cyc + 3;
        for (int j = 0; j < 36; j++) begin
            @(negedge ACLK);
            total++;
            if (obs !== exp_obs(cyc)) begin
                bad++;
                $display("FAIL reset_model cyc=%0d got=%b exp=%b", cyc, obs, exp_obs(cyc));
            end
            if (cyc <= c0) begin
                total++;
                if (obs !== {4'hF, 1'b1, 1'b0, 2'b00}) begin
                    bad++;
                    $display("FAIL reset_state cyc=%0d got=%b exp=%b", cyc, obs, {4'hF, 4'b1000});
                end
            end
            if (cyc == c0 + 16 || cyc == c0 + 17 || cyc == c0 + 21 || cyc == c0 + 25) begin
                logic [3:0] e;
                e = (cyc == c0 + 16) ? 4'hF : (cyc == c0 + 17) ? 4'hE : (cyc == c0 + 21) ? 4'hC : 4'h8;
                total++;
                if (rst_out !== e) begin
                    bad++;
                    $display("FAIL poweron_release cyc=%0d got=%h exp=%h", cyc, rst_out, e);
                end
            end
            if (cyc == c0 + 29) begin
                total++;
                if (rst_out !== 4'h0 || done !== 1'b1 || busy !== 1'b0) begin
                    bad++;
                    $display("FAIL poweron_done rst=%h done=%b busy=%b exp rst=0 done=1 busy=0", rst_out, done, busy);
                end
            end
            ARESET = (cyc <= c0);
            model_step();
        end
    endtask

    task automatic test_sparse();
        int t;
        t = cyc + 1;
        for (int j = 0; j < 26; j++) begin
            @(negedge ACLK);
            total++;
            if (obs !== exp_obs(cyc)) begin
                bad++;
                $display("FAIL sparse_model cyc=%0d got=%b exp=%b", cyc, obs, exp_obs(cyc));
            end
            if (cyc >= t + 1 && cyc <= t + 16) begin
                total++;
                if (rst_out !== 4'b0101) begin
                    bad++;
                    $display("FAIL sparse_hold cyc=%0d got=%b exp=0101", cyc, rst_out);
                end
            end
            if (cyc == t + 17 || cyc == t + 21) begin
                total++;
                if (rst_out !== ((cyc == t + 17) ? 4'b0100 : 4'b0000) || done !== (cyc == t + 21)) begin
                    bad++;
                    $display("FAIL sparse_release cyc=%0d rst=%b done=%b", cyc, rst_out, done);
                end
            end
            if (cyc == t) drive_stb(32'h8000_0005); else drive_idle();
            model_step();
        end
    endtask

    task automatic test_ext();
        int t;
        t = cyc + 1;
        for (int j = 0; j < 30; j++) begin
            @(negedge ACLK);
            total++;
            if (obs !== exp_obs(cyc)) begin
                bad++;
                $display("FAIL ext_model cyc=%0d got=%b exp=%b", cyc, obs, exp_obs(cyc));
            end
            if (cyc == t + 26 || cyc == t + 27) begin
                total++;
                if (rst_out[0] !== (cyc == t + 26) || done !== (cyc == t + 27)) begin
                    bad++;
                    $display("FAIL ext_hold cyc=%0d rst0=%b done=%b", cyc, rst_out[0], done);
                end
            end
            // A later ctrl_word change must not alter the captured EXT.
            if (cyc == t) drive_stb(32'h8000_0A01);
            else begin
                drive_idle();
                ctrl_word = 32'h0000_FF00;
            end
            model_step();
        end
    endtask

    task automatic test_overrun();
        int t;
        t = cyc + 1;
        for (int j = 0; j < 45; j++) begin
            @(negedge ACLK);
            total++;
            if (obs !== exp_obs(cyc)) begin
                bad++;
                $display("FAIL overrun_model cyc=%0d got=%b exp=%b", cyc, obs, exp_obs(cyc));
            end
            if (cyc >= t + 6 && cyc <= t + 23) begin
                total++;
                if (status !== 2'b10) begin
                    bad++;
                    $display("FAIL overrun_flag cyc=%0d got=%b exp=10", cyc, status);
                end
            end
            if (cyc == t + 21 || cyc == t + 24) begin
                total++;
                if (done !== (cyc == t + 21) || status !== ((cyc == t + 24) ? 2'b00 : 2'b10)) begin
                    bad++;
                    $display("FAIL overrun_done_clear cyc=%0d done=%b status=%b", cyc, done, status);
                end
            end
            if (cyc == t) drive_stb(32'h8000_0005);
            else if (cyc == t + 5) drive_stb(32'h8000_000F);
            else if (cyc == t + 23) drive_stb(32'h8000_0001);
            else drive_idle();
            model_step();
        end
    endtask

    task automatic test_errors();
        int t;
        t = cyc + 1;
        for (int j = 0; j < 8; j++) begin
            @(negedge ACLK);
            total++;
            if (obs !== exp_obs(cyc)) begin
                bad++;
                $display("FAIL errors_model cyc=%0d got=%b exp=%b", cyc, obs, exp_obs(cyc));
            end
            if (cyc >= t + 1) begin
                total++;
                if (obs !== {4'h0, 1'b0, 1'b0, 2'b01}) begin
                    bad++;
                    $display("FAIL errors_state cyc=%0d got=%b exp=00000001", cyc, obs);
                end
            end
            if (cyc == t) drive_stb(32'h8000_0000);
            else if (cyc == t + 2) drive_stb(32'h0000_000F);
            else if (cyc == t + 4) drive_stb(32'h8000_00F0);
            else drive_idle();
            model_step();
        end
    endtask

    task automatic test_reset_mid();
        int t;
        t = cyc + 1;
        for (int j = 0; j < 42; j++) begin
            @(negedge ACLK);
            total++;
            if (obs !== exp_obs(cyc)) begin
                bad++;
                $display("FAIL rstmid_model cyc=%0d got=%b exp=%b", cyc, obs, exp_obs(cyc));
            end
            if (cyc == t + 8 || cyc == t + 9 || cyc == t + 26) begin
                logic [3:0] e;
                e = (cyc == t + 8) ? 4'b0101 : (cyc == t + 9) ? 4'hF : 4'hE;
                total++;
                if (rst_out !== e) begin
                    bad++;
                    $display("FAIL rstmid_rst cyc=%0d got=%h exp=%h", cyc, rst_out, e);
                end
            end
            if (cyc == t + 38) begin
                total++;
                if (done !== 1'b1 || rst_out !== 4'h0) begin
                    bad++;
                    $display("FAIL rstmid_done got done=%b rst=%h exp done=1 rst=0", done, rst_out);
                end
            end
            ARESET = (cyc == t + 8 || cyc == t + 9);
            if (cyc == t) drive_stb(32'h8000_0005); else drive_idle();
            model_step();
        end
    endtask

    task automatic test_back_to_back();
        int t;
        t = cyc + 1;
        for (int j = 0; j < 38; j++) begin
            @(negedge ACLK);
            total++;
            if (obs !== exp_obs(cyc)) begin
                bad++;
                $display("FAIL b2b_model cyc=%0d got=%b exp=%b", cyc, obs, exp_obs(cyc));
            end
            if (cyc == t + 17 || cyc == t + 18) begin
                total++;
                if (done !== (cyc == t + 17) || busy !== (cyc == t + 18) ||
                    rst_out !== ((cyc == t + 18) ? 4'b0010 : 4'b0000)) begin
                    bad++;
                    $display("FAIL b2b_accept cyc=%0d rst=%b done=%b busy=%b", cyc, rst_out, done, busy);
                end
            end
            if (cyc == t) drive_stb(32'h8000_0001);
            else if (cyc == t + 17) drive_stb(32'h8000_0002);
            else drive_idle();
            model_step();
        end
    endtask

    task automatic test_random();
        logic       go;
        logic [7:0] ext;
        logic [7:0] mask;
        for (int j = 0; j < 800; j++) begin
            @(negedge ACLK);
            total++;
            if (obs !== exp_obs(cyc)) begin
                bad++;
                $display("FAIL random_model cyc=%0d got=%b exp=%b", cyc, obs, exp_obs(cyc));
            end
            go   = ($urandom_range(0, 4) != 0);
            ext  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 3));
            mask = 8'($urandom_range(0, 255));
            ctrl_word   = {go, 15'($urandom), ext, mask};
            ctrl_wr_stb = ($urandom_range(0, 5) == 0);
            ARESET      = ($urandom_range(0, 199) == 0);
            model_step();
        end
    endtask

    initial begin
        ARESET      = 1'b1;
        ctrl_word   = 32'h0;
        ctrl_wr_stb = 1'b0;
        model_step();
        test_reset();
        test_sparse();
        test_ext();
        test_overrun();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Consumes the control word held by the ResetReg AXI4-Lite register block and turns it into sequenced, stretched reset outputs for the VLC datapath sub-blocks.
- A software write with the GO bit set asserts the selected reset lines together and holds them for a programmable time.
- The lines are then released one at a time in ascending index order, with a fixed gap between releases.
- Also performs an all-channel sequence after system reset.

Parameters:
- N_OUT, 4, number of reset output channels (1..8).
- PULSE_CYCLES, 16, base hold time in cycles (>=1).
- GAP_CYCLES, 4, cycles between successive channel releases (>=1).

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  synchronous active-high reset.
- ctrl_word  in  32  register contents; [31]=GO, [15:8]=EXT extra hold cycles, [N_OUT-1:0]=MASK.
- ctrl_wr_stb  in  1  one-cycle pulse, high in the cycle ctrl_word was updated by an AXI write.
- rst_out  out  N_OUT  active-high resets to downstream blocks.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse when the last masked channel releases.
- status  out  2  sticky flags {overrun, req_err}.

Behaviour:
- Reset (ARESET=1): rst_out=all ones, busy=1, done=0, status=0.
  - Internally the block loads MASK=all ones and EXT=0, and the FSM enters HOLD with a cleared counter.
  - This behaves exactly like a request accepted in the last reset cycle, so the power-on sequence runs without software.
- ARESET mid-sequence aborts the current sequence and restarts the power-on sequence.
- FSM states:
  - IDLE:
    - busy=0.
    - Accepts a request when ctrl_wr_stb=1, GO=1 and MASK!=0.
  - HOLD:
    - Masked rst_out bits are high; unmasked bits stay 0.
    - Counts PULSE_CYCLES+EXT cycles, then goes to RELEASE.
  - RELEASE:
    - Deasserts the lowest-index still-asserted masked channel.
    - Waits GAP_CYCLES, then deasserts the next one. Unmasked indices are skipped with no gap.
    - After the last release, returns to IDLE.
- Timing for a request accepted at cycle t:
  - Masked rst_out bits are high from t+1 through t+P, where P=PULSE_CYCLES+EXT.
  - The first masked channel is low at t+P+1.
  - The k-th masked channel (k from 0) is low at t+P+1+k*GAP_CYCLES.
- done=1 and busy=0 in the same cycle the last masked channel first reads 0. A request may be accepted in that cycle.
- Hold counter is 9 bits minimum (P up to 255+PULSE_CYCLES). EXT is captured at acceptance, and later ctrl_word changes have no effect on an active sequence.
- Strobe with GO=1 while busy=1: request dropped, overrun set.
- Strobe with GO=1 and MASK=0 while idle: ignored, req_err set.
- Strobe with GO=0: ignored, no flag change.
- Sticky flags clear on the next accepted request, in the acceptance cycle. A simultaneous drop event cannot occur in that cycle because acceptance requires busy=0.
- MASK bits at or above N_OUT are ignored. A mask that is zero after truncation counts as MASK=0.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Power-on (N_OUT=4, defaults): release ARESET. Taking c1 as the first cycle with ARESET=0:
  - rst_out=4'hF through c16.
  - Bits 0, 1, 2, 3 go low at c17, c21, c25, c29 respectively.
  - done pulses at c29; busy=0 from c29.
- Sparse mask: idle, strobe with ctrl_word=0x8000_0005 at t.
  - rst_out[0] and rst_out[2] are high t+1..t+16; bits 1 and 3 stay 0.
  - rst_out[0] low at t+17; rst_out[2] low at t+21; done at t+21.
- Extended hold: strobe with ctrl_word=0x8000_0A01 at t.
  - rst_out[0] high t+1..t+26, low at t+27; done at t+27.
- Overrun: second strobe with 0x8000_000F at t+5 during the sparse-mask case.
  - Timing of the first sequence is unchanged; status=2'b10.
  - The next accepted strobe clears status to 0.
- Errors: idle strobe with 0x8000_0000 gives status=2'b01 and no rst_out change. Strobe with 0x0000_000F gives no effect.
- Reset mid-sequence: assert ARESET for 2 cycles at t+8 of a sequence.
  - rst_out=4'hF immediately, then the power-on sequence timing follows.
- Back-to-back: strobe 0x8000_0002 in the same cycle that done pulses for the previous sequence.
  - Accepted; rst_out[1] high the next cycle.
